// File: rtl/hci_datamover_initiator.sv
// Strided TCDM read/write burst initiator on one HCI port; folds read data into an XOR checksum.
// Latency: req one cycle after an accepted start, one word per grant, done one cycle after the last response.
// Backpressure: holds req/add/data/wen until gnt; throttles reads at MAX_OUT outstanding. Perf counters: HCI_DATAMOVER_PERF_EN.
module hci_datamover_initiator #(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [AW-1:0]    cfg_base_i,
    input  logic [AW-1:0]    cfg_stride_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic             cfg_we_i,
    input  logic [DW-1:0]    cfg_seed_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [DW-1:0]    checksum_o,
    output logic             tcdm_req_o,
    input  logic             tcdm_gnt_i,
    output logic [AW-1:0]    tcdm_add_o,
    output logic             tcdm_wen_o,
    output logic [DW/8-1:0]  tcdm_be_o,
    output logic [DW-1:0]    tcdm_data_o,
    input  logic             tcdm_r_valid_i,
    input  logic [DW-1:0]    tcdm_r_data_i,
    output logic [31:0]      perf_cycles_o,
    output logic [31:0]      perf_stall_o
);
    localparam int unsigned   CW      = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state_q, state_d;

    logic [AW-1:0]    add_q, stride_q;
    logic [DW-1:0]    data_q, checksum_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W:0]   k_q;
    logic [CW-1:0]    out_cnt_q, out_cnt_d;
    logic             we_q, err_q;
    logic             start_acc, throttle, req, gnt_acc, rd_inc, rd_dec, last_gnt, busy;

    assign start_acc = (state_q == IDLE) && start_i && !clear_i;
    // A response arriving this cycle frees a slot, so the request may stay up.
    assign throttle  = (out_cnt_q == MAX_CNT) && !tcdm_r_valid_i;
    assign req       = (state_q == ISSUE) && !throttle;
    assign gnt_acc   = req && tcdm_gnt_i;
    assign rd_inc    = gnt_acc && !we_q;
    assign rd_dec    = tcdm_r_valid_i && (out_cnt_q != '0);
    assign last_gnt  = gnt_acc && ((k_q + (LEN_W+1)'(1)) == {1'b0, len_q});
    assign busy      = (state_q == ISSUE) || (state_q == DRAIN);

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (rd_inc && !rd_dec)
            out_cnt_d = out_cnt_q + CW'(1);
        else if (!rd_inc && rd_dec)
            out_cnt_d = out_cnt_q - CW'(1);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = (cfg_len_i != '0) ? ISSUE : DONE;
            ISSUE:   if (last_gnt) state_d = DRAIN;
            DRAIN:   if (out_cnt_d == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_i)
            state_d = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            add_q      <= '0;
            stride_q   <= '0;
            data_q     <= '0;
            len_q      <= '0;
            we_q       <= 1'b0;
            k_q        <= '0;
            out_cnt_q  <= '0;
            checksum_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clear_i) begin
                k_q       <= '0;
                out_cnt_q <= '0;
            end else begin
                out_cnt_q <= out_cnt_d;
                if (start_acc) begin
                    add_q    <= cfg_base_i;
                    stride_q <= cfg_stride_i;
                    data_q   <= cfg_seed_i;
                    len_q    <= cfg_len_i;
                    we_q     <= cfg_we_i;
                    k_q      <= '0;
                end else if (gnt_acc) begin
                    add_q  <= add_q + stride_q;
                    data_q <= data_q + DW'(1);
                    k_q    <= k_q + (LEN_W+1)'(1);
                end
            end
            // Checksum and error survive a clear; only a new start wipes them.
            if (start_acc) begin
                checksum_q <= '0;
                err_q      <= 1'b0;
            end else if (tcdm_r_valid_i) begin
                checksum_q <= checksum_q ^ tcdm_r_data_i;
                if (out_cnt_q == '0)
                    err_q <= 1'b1;
            end
        end
    end

`ifdef HCI_DATAMOVER_PERF_EN
    logic [31:0] perf_cycles_q, perf_stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else if (start_acc) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (busy && (perf_cycles_q != '1))
                perf_cycles_q <= perf_cycles_q + 32'd1;
            if (req && !tcdm_gnt_i && (perf_stall_q != '1))
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_cycles_o = perf_cycles_q;
    assign perf_stall_o  = perf_stall_q;
`else
    assign perf_cycles_o = '0;
    assign perf_stall_o  = '0;
`endif

    assign busy_o      = busy;
    assign done_o      = (state_q == DONE);
    assign err_o       = err_q;
    assign checksum_o  = checksum_q;
    assign tcdm_req_o  = req;
    assign tcdm_add_o  = add_q;
    assign tcdm_wen_o  = ~we_q;
    assign tcdm_be_o   = '1;
    assign tcdm_data_o = data_q;
endmodule

// File: tb/tb_hci_datamover_initiator.sv
// Scoreboard bench for hci_datamover_initiator: expected beats and completions are queued at stimulus time
// and consumed by a monitor that samples the TCDM port on the falling clock edge.
module tb_hci_datamover_initiator;
    logic        clk, rst, clear, start;
    logic [31:0] cfg_base, cfg_stride, cfg_seed;
    logic [15:0] cfg_len;
    logic        cfg_we;
    logic        busy, done, err;
    logic [31:0] checksum;
    logic        req, gnt, wen, r_valid;
    logic [31:0] add, wdata, r_data;
    logic [3:0]  be;
    logic [31:0] perf_cycles, perf_stall;

    hci_datamover_initiator #(.DW(32), .AW(32), .LEN_W(16), .MAX_OUT(4)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
        .cfg_base_i(cfg_base), .cfg_stride_i(cfg_stride), .cfg_len_i(cfg_len),
        .cfg_we_i(cfg_we), .cfg_seed_i(cfg_seed),
        .busy_o(busy), .done_o(done), .err_o(err), .checksum_o(checksum),
        .tcdm_req_o(req), .tcdm_gnt_i(gnt), .tcdm_add_o(add), .tcdm_wen_o(wen),
        .tcdm_be_o(be), .tcdm_data_o(wdata), .tcdm_r_valid_i(r_valid),
        .tcdm_r_data_i(r_data), .perf_cycles_o(perf_cycles), .perf_stall_o(perf_stall)
    );

    typedef struct packed {logic [31:0] add; logic wen; logic [31:0] data;} beat_t;
    typedef struct packed {logic [31:0] checksum; logic err;} fin_t;
    beat_t exp_req_q[$];
    fin_t  exp_done_q[$];

    int checks = 0, failures = 0;
    int cyc = 0, gnt_cnt = 0, done_cnt = 0, req_cnt = 0;
    int last_gnt_cyc = 0, last_rv_cyc = 0, done_cyc = 0;
    int gnt_mode = 0, auto_rsp = 0, manual_tok = 0;
    int s_cyc = 0, d0 = 0, g0 = 0, r0 = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus model: grant policy and read responses, driven 2 time units after the rising edge.
    initial begin : bus_model
        int  stall_seen;
        int  manual_used;
        bit  rd_acc;
        logic [31:0] rd_addr;
        stall_seen = 0; manual_used = 0;
        gnt = 0; r_valid = 0; r_data = '0;
        forever begin
            @(negedge clk);
            rd_acc  = req && gnt && wen && !rst;
            rd_addr = add;
            if (rst) stall_seen = 0;
            else if (req && !gnt) stall_seen++;
            else if (req && gnt) stall_seen = 0;
            @(posedge clk);
            #2;
            gnt = (gnt_mode == 0) ? 1'b1 : (stall_seen >= 3);
            if (auto_rsp != 0 && rd_acc) begin
                r_valid = 1; r_data = 32'h1 << rd_addr[6:2];
            end else if (manual_tok != manual_used) begin
                r_valid = 1; r_data = 32'h1 << manual_used; manual_used++;
            end else begin
                r_valid = 0; r_data = '0;
            end
        end
    end

    initial begin : monitor
        bit prev_stall, prev_done;
        logic [64:0] prev_beat;
        beat_t e;
        fin_t  f;
        prev_stall = 0; prev_done = 0; prev_beat = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0; prev_done = 0;
            end else begin
                if (req) req_cnt++;
                if (r_valid) last_rv_cyc = cyc;
                if (req && prev_stall) check("hold_stable", {add, wen, wdata}, prev_beat);
                if (req && gnt) begin
                    gnt_cnt++; last_gnt_cyc = cyc;
                    if (exp_req_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_req: got add=%0h wen=%0b expected no request", add, wen);
                    end else begin
                        e = exp_req_q.pop_front();
                        check("req_beat", {add, wen, wdata, be}, {e.add, e.wen, e.data, 4'hF});
                    end
                end
                prev_stall = req && !gnt;
                prev_beat  = {add, wen, wdata};
                if (done) begin
                    done_cnt++; done_cyc = cyc;
                    check("done_pulse_width", {31'd0, prev_done}, 32'd0);
                    check("done_busy", {31'd0, busy}, 32'd0);
                    if (exp_done_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_done: got done with checksum=%0h expected none", checksum);
                    end else begin
                        f = exp_done_q.pop_front();
                        check("done_checksum", checksum, f.checksum);
                        check("done_err", {31'd0, err}, {31'd0, f.err});
                    end
                end
                prev_done = done;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [31:0] a, input logic w, input logic [31:0] d);
        exp_req_q.push_back('{add: a, wen: w, data: d});
    endtask

    task automatic push_done(input logic [31:0] cs, input logic e);
        exp_done_q.push_back('{checksum: cs, err: e});
    endtask

    task automatic do_start(input logic [31:0] b, input logic [31:0] s, input logic [15:0] l,
                            input logic w, input logic [31:0] seed);
        d0 = done_cnt; g0 = gnt_cnt; r0 = req_cnt;
        tick();
        cfg_base = b; cfg_stride = s; cfg_len = l; cfg_we = w; cfg_seed = seed;
        start = 1; s_cyc = cyc;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            settle();
            if (done_cnt != d0) break;
        end
        check(name, {31'd0, done_cnt != d0}, 32'd1);
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_ctrl"}, {busy, done, err, req, wen}, 5'b00001);
        check({tag, "_add"}, add, 32'h0);
        check({tag, "_data"}, wdata, 32'h0);
        check({tag, "_checksum"}, checksum, 32'h0);
        check({tag, "_be"}, be, 4'hF);
        check({tag, "_perf"}, {perf_cycles, perf_stall}, 64'h0);
    endtask

    initial begin : stimulus
        rst = 1; clear = 0; start = 0;
        cfg_base = '0; cfg_stride = '0; cfg_len = '0; cfg_we = 0; cfg_seed = '0;
        repeat (3) @(posedge clk);
        settle();
        reset_check("por");
        tick();
        rst = 0;

        // Read burst, always granted, responses one cycle later.
        auto_rsp = 1;
        for (int k = 0; k < 16; k++) push_beat(32'(4 * k), 1'b1, 32'h11 + 32'(k));
        push_done(32'h0000FFFF, 1'b0);
        do_start(32'h0, 32'h4, 16'd16, 1'b0, 32'h11);
        wait_done("rd_timeout", 60);
        check("rd_grants", gnt_cnt - g0, 16);
        check("rd_last_gnt_cyc", last_gnt_cyc, s_cyc + 16);
        check("rd_done_after_rv", done_cyc, last_rv_cyc + 1);
        settle(); settle();
        check("rd_checksum_held", checksum, 32'h0000FFFF);
        auto_rsp = 0;

        // Write burst.
        push_beat(32'h100, 1'b0, 32'hA0); push_beat(32'h108, 1'b0, 32'hA1);
        push_beat(32'h110, 1'b0, 32'hA2); push_beat(32'h118, 1'b0, 32'hA3);
        push_done(32'h0, 1'b0);
        do_start(32'h100, 32'h8, 16'd4, 1'b1, 32'hA0);
        wait_done("wr_timeout", 30);
        check("wr_last_gnt_cyc", last_gnt_cyc, s_cyc + 4);
        check("wr_done_after_gnt", done_cyc, last_gnt_cyc + 2);

        // Backpressure: three refused cycles per word.
        gnt_mode = 1;
        push_beat(32'h200, 1'b0, 32'h5); push_beat(32'h204, 1'b0, 32'h6); push_beat(32'h208, 1'b0, 32'h7);
        push_done(32'h0, 1'b0);
        do_start(32'h200, 32'h4, 16'd3, 1'b1, 32'h5);
        wait_done("bp_timeout", 80);
        check("bp_done_cyc", done_cyc, s_cyc + 14);
        settle();
`ifdef HCI_DATAMOVER_PERF_EN
        check("bp_perf_stall", perf_stall, 32'd9);
        check("bp_perf_cycles", perf_cycles, 32'd13);
`else
        check("bp_perf_off", {perf_cycles, perf_stall}, 64'h0);
`endif
        gnt_mode = 0;

        // Throttle at four outstanding reads, responses released by hand.
        for (int k = 0; k < 8; k++) push_beat(32'(4 * k), 1'b1, 32'(k));
        push_done(32'h000000FF, 1'b0);
        do_start(32'h0, 32'h4, 16'd8, 1'b0, 32'h0);
        repeat (8) settle();
        check("thr_grants", gnt_cnt - g0, 4);
        check("thr_req_low", {31'd0, req}, 32'd0);
        manual_tok = 1;
        repeat (3) settle();
        check("thr_one_more", gnt_cnt - g0, 5);
        check("thr_req_low2", {31'd0, req}, 32'd0);
        manual_tok = 8;
        wait_done("thr_timeout", 40);

        // Zero length: done straight away, no request.
        push_done(32'h0, 1'b0);
        do_start(32'h500, 32'h4, 16'd0, 1'b0, 32'h0);
        wait_done("len0_timeout", 10);
        check("len0_done_cyc", done_cyc, s_cyc + 1);
        check("len0_no_req", req_cnt, r0);

        // Address and data wrap.
        push_beat(32'h4, 1'b0, 32'hFFFFFFFF); push_beat(32'h0, 1'b0, 32'h0);
        push_beat(32'hFFFFFFFC, 1'b0, 32'h1);
        push_done(32'h0, 1'b0);
        do_start(32'h4, 32'hFFFFFFFC, 16'd3, 1'b1, 32'hFFFFFFFF);
        wait_done("wrap_timeout", 20);

        // Start while busy is ignored.
        gnt_mode = 1; auto_rsp = 1;
        push_beat(32'h40, 1'b1, 32'h30); push_beat(32'h44, 1'b1, 32'h31);
        push_beat(32'h48, 1'b1, 32'h32); push_beat(32'h4C, 1'b1, 32'h33);
        push_done(32'h000F0000, 1'b0);
        do_start(32'h40, 32'h4, 16'd4, 1'b0, 32'h30);
        repeat (4) tick();
        cfg_base = 32'h900; cfg_stride = 32'h8; cfg_len = 16'd2; cfg_we = 1; cfg_seed = 32'h77;
        start = 1;
        tick();
        start = 0;
        wait_done("busy_start_timeout", 60);
        check("busy_start_grants", gnt_cnt - g0, 4);
        gnt_mode = 0; auto_rsp = 0;

        // Clear mid-issue, then a late response flags an error.
        push_beat(32'h0, 1'b1, 32'h60); push_beat(32'h4, 1'b1, 32'h61); push_beat(32'h8, 1'b1, 32'h62);
        do_start(32'h0, 32'h4, 16'd8, 1'b0, 32'h60);
        tick(); tick();
        clear = 1;
        tick();
        clear = 0;
        settle();
        check("clr_req_low", {busy, req}, 2'b00);
        repeat (5) settle();
        check("clr_no_done", done_cnt, d0);
        check("clr_grants", gnt_cnt - g0, 3);
        check("clr_err_before", {31'd0, err}, 32'd0);
        manual_tok = 9;
        repeat (3) settle();
        check("clr_late_err", {31'd0, err}, 32'd1);
        check("clr_checksum", checksum, 32'h00000100);

        // Asynchronous reset in the middle of a stalled write burst.
        gnt_mode = 1;
        push_beat(32'h300, 1'b0, 32'h50);
        do_start(32'h300, 32'h4, 16'd8, 1'b1, 32'h50);
        repeat (5) tick();
        #2;
        rst = 1;
        #1;
        reset_check("mid");
        @(posedge clk);
        gnt_mode = 0;
        tick();
        rst = 0;
        check("rst_req_queue", exp_req_q.size(), 0);

        // Normal operation after reset.
        push_beat(32'h10, 1'b0, 32'h7); push_beat(32'h14, 1'b0, 32'h8);
        push_done(32'h0, 1'b0);
        do_start(32'h10, 32'h4, 16'd2, 1'b1, 32'h7);
        wait_done("post_rst_timeout", 20);
        settle();
        check("end_req_queue", exp_req_q.size(), 0);
        check("end_done_queue", exp_done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
